// File: rtl/mdp3_order_book_if.sv
// Parser-to-book entry bus plus the top-of-book and status outputs of one security.
interface mdp3_order_book_if;
  logic               message_ready;
  logic [1:0]         ACTION;
  logic [1:0]         ENTRY_TYPE;
  logic signed [63:0] PRICE;
  logic [15:0]        QUANTITY;
  logic [7:0]         NUM_ORDERS;
  logic [31:0]        SECURITY_ID;

  logic               best_bid_valid;
  logic               best_ask_valid;
  logic signed [63:0] best_bid_price;
  logic signed [63:0] best_ask_price;
  logic [15:0]        best_bid_qty;
  logic [15:0]        best_ask_qty;
  logic [7:0]         best_bid_orders;
  logic [7:0]         best_ask_orders;
  logic               book_updated;
  logic               busy;
  logic [15:0]        reject_count;
  logic [15:0]        drop_count;

  modport master (
    output message_ready, ACTION, ENTRY_TYPE, PRICE, QUANTITY, NUM_ORDERS, SECURITY_ID,
    input  best_bid_valid, best_ask_valid, best_bid_price, best_ask_price,
           best_bid_qty, best_ask_qty, best_bid_orders, best_ask_orders,
           book_updated, busy, reject_count, drop_count
  );

  modport slave (
    input  message_ready, ACTION, ENTRY_TYPE, PRICE, QUANTITY, NUM_ORDERS, SECURITY_ID,
    output best_bid_valid, best_ask_valid, best_bid_price, best_ask_price,
           best_bid_qty, best_ask_qty, best_bid_orders, best_ask_orders,
           book_updated, busy, reject_count, drop_count
  );
endinterface

// File: rtl/mdp3_order_book.sv
// Sorted DEPTH-level bid/offer book for one security; IDLE->SEARCH->UPDATE->PUBLISH per entry,
// book visible 3 cycles after the message_ready edge; edges arriving while busy are dropped and counted.
module mdp3_order_book #(
  parameter int          DEPTH           = 4,
  parameter bit          FILTER_EN       = 1'b1,
  parameter logic [31:0] SECURITY_FILTER = 32'd0
) (
  input logic              clk,
  input logic              reset,
  mdp3_order_book_if.slave bus
);
  localparam int IW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic               vld;
    logic signed [63:0] px;
    logic [15:0]        qty;
    logic [7:0]         ord;
  } level_t;

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, PUBLISH} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mr_q;
  logic [1:0]         r_action, r_type;
  logic signed [63:0] r_px;
  logic [15:0]        r_qty;
  logic [7:0]         r_ord;
  logic [31:0]        r_sec;
  logic               r_match_found;
  logic [IW-1:0]      r_match_idx, r_ins_idx;
  logic [15:0]        r_reject_cnt, r_drop_cnt;
  level_t             r_bid [DEPTH];
  level_t             r_ask [DEPTH];

  level_t             w_cur [DEPTH];
  level_t             w_nxt [DEPTH];
  logic               w_edge, w_reject, w_match_found, w_ins_found, w_better;
  logic [IW-1:0]      w_match_idx, w_ins_idx;
  logic               w_busy, w_book_updated;

  assign w_edge = bus.message_ready & ~r_mr_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cur[i] = (r_type == 2'd0) ? r_bid[i] : r_ask[i];
    end
  end

  // Valid levels are contiguous, so the first invalid or worse slot is the insert point.
  always_comb begin
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_ins_found   = 1'b0;
    w_ins_idx     = IW'(DEPTH);
    w_better      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_better = (r_type == 2'd0) ? ($signed(r_px) > $signed(w_cur[i].px))
                                  : ($signed(r_px) < $signed(w_cur[i].px));
      if (!w_match_found && w_cur[i].vld && (w_cur[i].px == r_px)) begin
        w_match_found = 1'b1;
        w_match_idx   = IW'(i);
      end
      if (!w_ins_found && (!w_cur[i].vld || w_better)) begin
        w_ins_found = 1'b1;
        w_ins_idx   = IW'(i);
      end
    end
  end

  assign w_reject = (FILTER_EN && (r_sec != SECURITY_FILTER)) || (r_action == 2'd3) ||
                    r_type[1] || ((r_action != 2'd0) && !w_match_found);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = w_cur[i];
    end
    case (r_action)
      2'd0: begin
        if (r_match_found) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(r_match_idx)) begin
              w_nxt[i].qty = r_qty;
              w_nxt[i].ord = r_ord;
            end
          end
        end else if (int'(r_ins_idx) < DEPTH) begin
          for (int i = 1; i < DEPTH; i++) begin
            if (i > int'(r_ins_idx)) w_nxt[i] = w_cur[i-1];
          end
          for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(r_ins_idx)) w_nxt[i] = {1'b1, r_px, r_qty, r_ord};
          end
        end
      end
      2'd1: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(r_match_idx)) begin
            w_nxt[i].qty = r_qty;
            w_nxt[i].ord = r_ord;
          end
        end
      end
      2'd2: begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= int'(r_match_idx)) w_nxt[i] = w_cur[i+1];
        end
        w_nxt[DEPTH-1] = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_busy         = (r_state != IDLE);
    w_book_updated = 1'b0;
    case (r_state)
      IDLE:    if (w_edge) w_state_nxt = SEARCH;
      SEARCH:  w_state_nxt = w_reject ? IDLE : UPDATE;
      UPDATE:  w_state_nxt = PUBLISH;
      PUBLISH: begin
        w_book_updated = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_mr_q        <= 1'b1;
      r_action      <= '0;
      r_type        <= '0;
      r_px          <= '0;
      r_qty         <= '0;
      r_ord         <= '0;
      r_sec         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_ins_idx     <= '0;
      r_reject_cnt  <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mr_q  <= bus.message_ready;
      if (r_state == IDLE && w_edge) begin
        r_action <= bus.ACTION;
        r_type   <= bus.ENTRY_TYPE;
        r_px     <= bus.PRICE;
        r_qty    <= bus.QUANTITY;
        r_ord    <= bus.NUM_ORDERS;
        r_sec    <= bus.SECURITY_ID;
      end
      if (r_state == SEARCH) begin
        r_match_found <= w_match_found;
        r_match_idx   <= w_match_idx;
        r_ins_idx     <= w_ins_idx;
        if (w_reject && r_reject_cnt != 16'hFFFF) r_reject_cnt <= r_reject_cnt + 16'd1;
      end
      if (w_edge && r_state != IDLE && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bid[i] <= '0;
        r_ask[i] <= '0;
      end
    end else if (r_state == UPDATE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_type == 2'd0) r_bid[i] <= w_nxt[i];
        else                r_ask[i] <= w_nxt[i];
      end
    end
  end

  assign bus.best_bid_valid  = r_bid[0].vld;
  assign bus.best_bid_price  = r_bid[0].vld ? r_bid[0].px  : '0;
  assign bus.best_bid_qty    = r_bid[0].vld ? r_bid[0].qty : '0;
  assign bus.best_bid_orders = r_bid[0].vld ? r_bid[0].ord : '0;
  assign bus.best_ask_valid  = r_ask[0].vld;
  assign bus.best_ask_price  = r_ask[0].vld ? r_ask[0].px  : '0;
  assign bus.best_ask_qty    = r_ask[0].vld ? r_ask[0].qty : '0;
  assign bus.best_ask_orders = r_ask[0].vld ? r_ask[0].ord : '0;
  assign bus.book_updated    = w_book_updated;
  assign bus.busy            = w_busy;
  assign bus.reject_count    = r_reject_cnt;
  assign bus.drop_count      = r_drop_cnt;
endmodule

// File: tb/tb_mdp3_order_book.sv
// Directed bench for mdp3_order_book: DEPTH 4, filter on security 42.
module tb_mdp3_order_book;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mdp3_order_book_if bus();

  mdp3_order_book #(.DEPTH(4), .FILTER_EN(1'b1), .SECURITY_FILTER(32'd42)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One entry: book_updated must appear 3 cycles after the sampling edge, or never if rejected.
  task automatic send(input string tag, input logic [1:0] act, input logic [1:0] typ,
                      input logic signed [63:0] px, input logic [15:0] q, input logic [7:0] o,
                      input logic [31:0] sec, input bit exp_upd);
    int first;
    int pulses;
    first  = 0;
    pulses = 0;
    @(negedge clk);
    bus.ACTION        = act;
    bus.ENTRY_TYPE    = typ;
    bus.PRICE         = px;
    bus.QUANTITY      = q;
    bus.NUM_ORDERS    = o;
    bus.SECURITY_ID   = sec;
    bus.message_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (bus.book_updated) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 1) begin
        @(negedge clk);
        bus.message_ready = 1'b0;
      end
    end
    if (exp_upd) chk({tag, "_upd_cycle"}, 64'(first), 64'd3);
    else         chk({tag, "_no_upd"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    int seen_busy;
    int pulses;
    bus.message_ready = 1'b1;
    bus.ACTION        = '0;
    bus.ENTRY_TYPE    = '0;
    bus.PRICE         = '0;
    bus.QUANTITY      = '0;
    bus.NUM_ORDERS    = '0;
    bus.SECURITY_ID   = '0;

    // Reset released with message_ready already high.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_busy = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.book_updated) seen_busy++;
    end
    chk("rst_no_entry", 64'(seen_busy), 64'd0);
    chk("rst_bid_valid", 64'(bus.best_bid_valid), 64'd0);
    chk("rst_ask_valid", 64'(bus.best_ask_valid), 64'd0);
    chk("rst_bid_price", bus.best_bid_price, 64'd0);
    chk("rst_ask_qty", 64'(bus.best_ask_qty), 64'd0);
    chk("rst_reject", 64'(bus.reject_count), 64'd0);
    chk("rst_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);
    bus.message_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Bids 100, 102, 101.
    send("bid100", 2'd0, 2'd0, 64'sd100, 16'd5, 8'd1, 32'd42, 1'b1);
    chk("bid100_px", bus.best_bid_price, 64'd100);
    send("bid102", 2'd0, 2'd0, 64'sd102, 16'd6, 8'd2, 32'd42, 1'b1);
    send("bid101", 2'd0, 2'd0, 64'sd101, 16'd7, 8'd1, 32'd42, 1'b1);
    chk("bids_valid", 64'(bus.best_bid_valid), 64'd1);
    chk("bids_px", bus.best_bid_price, 64'd102);
    chk("bids_qty", 64'(bus.best_bid_qty), 64'd6);

    // Change on existing and missing prices.
    send("chg102", 2'd1, 2'd0, 64'sd102, 16'd9, 8'd3, 32'd42, 1'b1);
    chk("chg_px", bus.best_bid_price, 64'd102);
    chk("chg_qty", 64'(bus.best_bid_qty), 64'd9);
    chk("chg_ord", 64'(bus.best_bid_orders), 64'd3);
    send("chg999", 2'd1, 2'd0, 64'sd999, 16'd1, 8'd1, 32'd42, 1'b0);
    chk("chg999_rej", 64'(bus.reject_count), 64'd1);

    // Filter mismatch and reserved action.
    send("sec43", 2'd0, 2'd0, 64'sd500, 16'd1, 8'd1, 32'd43, 1'b0);
    send("act3", 2'd3, 2'd0, 64'sd500, 16'd1, 8'd1, 32'd42, 1'b0);
    chk("filt_rej", 64'(bus.reject_count), 64'd3);
    chk("filt_px", bus.best_bid_price, 64'd102);
    chk("filt_qty", 64'(bus.best_bid_qty), 64'd9);

    // Offers: fill, worse-than-all on a full side, better insert evicts the tail, delete.
    send("ask10", 2'd0, 2'd1, 64'sd10, 16'd1, 8'd1, 32'd42, 1'b1);
    send("ask20", 2'd0, 2'd1, 64'sd20, 16'd2, 8'd1, 32'd42, 1'b1);
    send("ask30", 2'd0, 2'd1, 64'sd30, 16'd3, 8'd1, 32'd42, 1'b1);
    send("ask40", 2'd0, 2'd1, 64'sd40, 16'd4, 8'd1, 32'd42, 1'b1);
    send("ask50", 2'd0, 2'd1, 64'sd50, 16'd5, 8'd1, 32'd42, 1'b1);
    chk("ask50_px", bus.best_ask_price, 64'd10);
    chk("ask50_qty", 64'(bus.best_ask_qty), 64'd1);
    send("ask5", 2'd0, 2'd1, 64'sd5, 16'd8, 8'd2, 32'd42, 1'b1);
    chk("ask5_px", bus.best_ask_price, 64'd5);
    chk("ask5_qty", 64'(bus.best_ask_qty), 64'd8);
    send("del5", 2'd2, 2'd1, 64'sd5, 16'd0, 8'd0, 32'd42, 1'b1);
    chk("del5_px", bus.best_ask_price, 64'd10);
    send("del10", 2'd2, 2'd1, 64'sd10, 16'd0, 8'd0, 32'd42, 1'b1);
    send("del20", 2'd2, 2'd1, 64'sd20, 16'd0, 8'd0, 32'd42, 1'b1);
    chk("del20_px", bus.best_ask_price, 64'd30);
    send("del30", 2'd2, 2'd1, 64'sd30, 16'd0, 8'd0, 32'd42, 1'b1);
    // 40 was evicted and 50 never stored, so the side is empty now.
    chk("asks_empty", 64'(bus.best_ask_valid), 64'd0);
    chk("asks_empty_px", bus.best_ask_price, 64'd0);
    send("del77", 2'd2, 2'd1, 64'sd77, 16'd0, 8'd0, 32'd42, 1'b0);
    chk("del77_rej", 64'(bus.reject_count), 64'd4);

    // Signed ordering on offers.
    send("askm5", 2'd0, 2'd1, -64'sd5, 16'd2, 8'd1, 32'd42, 1'b1);
    send("ask3", 2'd0, 2'd1, 64'sd3, 16'd4, 8'd1, 32'd42, 1'b1);
    chk("signed_px", bus.best_ask_price, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("signed_qty", 64'(bus.best_ask_qty), 64'd2);

    // Zero quantity is stored as a level.
    send("bid103q0", 2'd0, 2'd0, 64'sd103, 16'd0, 8'd4, 32'd42, 1'b1);
    chk("q0_valid", 64'(bus.best_bid_valid), 64'd1);
    chk("q0_px", bus.best_bid_price, 64'd103);
    chk("q0_qty", 64'(bus.best_bid_qty), 64'd0);

    // Second edge while busy, then a level held high.
    pulses = 0;
    @(negedge clk);
    bus.ACTION        = 2'd0;
    bus.ENTRY_TYPE    = 2'd0;
    bus.PRICE         = 64'sd104;
    bus.QUANTITY      = 16'd1;
    bus.NUM_ORDERS    = 8'd1;
    bus.SECURITY_ID   = 32'd42;
    bus.message_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (bus.book_updated) pulses++;
      if (c == 1) begin
        @(negedge clk);
        bus.message_ready = 1'b0;
      end else if (c == 2) begin
        @(negedge clk);
        bus.message_ready = 1'b1;
      end
    end
    chk("drop_pulses", 64'(pulses), 64'd1);
    chk("drop_count", 64'(bus.drop_count), 64'd1);
    chk("drop_px", bus.best_bid_price, 64'd104);
    chk("drop_idle", 64'(bus.busy), 64'd0);
    chk("drop_rej", 64'(bus.reject_count), 64'd4);
    @(negedge clk);
    bus.message_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
